wb_write_arbiter: RTL

// - Writeback-side producer for the 2-write/3-read register storage cells. Collects results from 3 sources.
// - Each source uses a valid/ready handshake. Results are queued per source.
// - Up to 2 writes issue per cycle on write ports 1 and 2.
// - Sits between functional-unit result buses and the register storage write ports.
// - Arbitration is round-robin. Same-address conflicts are resolved so that no write is lost.

---
 rtl/wb_arb_pkg.sv | 18 +
 rtl/wb_src_fifo.sv | 56 +++++
 rtl/wb_write_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the writeback arbiter: source count, the queued
// request record and the round-robin pointer advance.
package wb_arb_pkg;

  localparam int NUM_SRC       = 3;
  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 32;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req_t;

  function automatic logic [1:0] rr_advance(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source 1-push/1-pop request queue. Push is refused while full (no
// same-cycle bypass); the head is visible the cycle after the push edge.
module wb_src_fifo
  import wb_arb_pkg::*;
#(
  parameter type T     = wb_req_t,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  T     i_din,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output T     o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  T               r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [PW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: three per-source queues feeding two register-file write
// ports, round-robin picked, with same-address pairs split across cycles.
module wb_write_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_SRC-1:0]                  src_valid_i,
  input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]  src_addr_i,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  src_data_i,
  output logic [NUM_SRC-1:0]                  src_ready_o,
  input  logic                                stall_i,
  output logic                                write1_en_o,
  output logic [ADDR_WIDTH-1:0]               write1_addr_o,
  output logic [DATA_WIDTH-1:0]               data1_o,
  output logic                                write2_en_o,
  output logic [ADDR_WIDTH-1:0]               write2_addr_o,
  output logic [DATA_WIDTH-1:0]               data2_o,
  output logic                                idle_o
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  req_t               w_din  [NUM_SRC];
  req_t               w_head [NUM_SRC];
  logic [NUM_SRC-1:0] w_full;
  logic [NUM_SRC-1:0] w_empty;
  logic [NUM_SRC-1:0] w_pop;
  logic [1:0]         r_rr_ptr;
  logic               w_v1, w_v2, w_done;
  logic [1:0]         w_s1, w_s2, w_idx;
  logic               w_issue1, w_issue2;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign w_din[k] = req_t'{addr: src_addr_i[k], data: src_data_i[k]};

    wb_src_fifo #(.T(req_t), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (src_valid_i[k]),
      .i_din   (w_din[k]),
      .i_pop   (w_pop[k]),
      .o_full  (w_full[k]),
      .o_empty (w_empty[k]),
      .o_head  (w_head[k])
    );
  end

  assign src_ready_o = ~w_full;
  assign idle_o      = &w_empty;

  // Scan from rr_ptr; the second non-empty head ends the scan whether or not
  // it issues, so a same-address younger write never overtakes the older one.
  always_comb begin
    w_v1   = 1'b0;
    w_v2   = 1'b0;
    w_s1   = 2'd0;
    w_s2   = 2'd0;
    w_done = 1'b0;
    w_idx  = r_rr_ptr;
    for (int o = 0; o < NUM_SRC; o++) begin
      if (!w_done && !w_empty[w_idx]) begin
        if (!w_v1) begin
          w_v1 = 1'b1;
          w_s1 = w_idx;
        end else begin
          w_v2   = (w_head[w_idx].addr != w_head[w_s1].addr);
          w_s2   = w_idx;
          w_done = 1'b1;
        end
      end
      w_idx = rr_advance(w_idx);
    end
  end

  assign w_issue1 = w_v1 && !stall_i;
  assign w_issue2 = w_v2 && !stall_i;

  always_comb begin
    w_pop = '0;
    if (w_issue1) w_pop[w_s1] = 1'b1;
    if (w_issue2) w_pop[w_s2] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= 2'd0;
    end else if (w_issue1) begin
      r_rr_ptr <= rr_advance(w_issue2 ? w_s2 : w_s1);
    end
  end

  assign write1_en_o   = w_issue1;
  assign write1_addr_o = w_issue1 ? w_head[w_s1].addr : '0;
  assign data1_o       = w_issue1 ? w_head[w_s1].data : '0;
  assign write2_en_o   = w_issue2;
  assign write2_addr_o = w_issue2 ? w_head[w_s2].addr : '0;
  assign data2_o       = w_issue2 ? w_head[w_s2].data : '0;

endmodule
